// File: rtl/axi_pkg.sv
// AXI read-channel encodings and the refill FSM state type shared by the refill master.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    DRAIN,
    DONE
  } refill_state_e;

endpackage

// File: rtl/refill_line_buf.sv
// Cache-line assembly buffer: LINE_BEATS x 64-bit slots, one slot written per beat, exposed flat.
module refill_line_buf #(
  parameter int LINE_BEATS = 4,
  parameter int IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [63:0]                wdata_i,
  output logic [64*LINE_BEATS-1:0]   line_o
);

  logic [63:0] slot_q [LINE_BEATS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LINE_BEATS; i++) slot_q[i] <= '0;
    end else if (we_i) begin
      slot_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LINE_BEATS; g++) begin : g_flat
    assign line_o[64*g +: 64] = slot_q[g];
  end

endmodule

// File: rtl/axi_refill_master.sv
// AXI4 read master fetching one cache line per request with one outstanding burst.
// Define AXI_REFILL_WRAP_EN for critical-word-first WRAP bursts; default is INCR from the line base.
module axi_refill_master
  import axi_pkg::*;
#(
  parameter int         LINE_BEATS = 4,
  parameter int         ADDR_W     = 32,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       refill_req,
  input  logic [ADDR_W-1:0]          refill_addr,
  output logic                       refill_ready,
  output logic                       refill_valid,
  output logic [64*LINE_BEATS-1:0]   refill_line,
  output logic                       refill_err,
  output logic [ADDR_W-1:0]          araddr,
  output logic [3:0]                 arid,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [63:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the master holds arvalid and AR fields stable until arready.

  localparam int LW = $clog2(LINE_BEATS);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0]     LAST_RCV  = CW'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS * 8 - 1);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     rcv_q, rcv_d;
  logic              err_q, err_d;
  logic              buf_we;
  logic [ADDR_W-1:0] start_addr;
  logic [CW-1:0]     start_idx;

`ifdef AXI_REFILL_WRAP_EN
  localparam logic [1:0] BURST = AXI_BURST_WRAP;
  assign start_addr = refill_addr & ~ADDR_W'(7);
  assign start_idx  = {1'b0, refill_addr[3 +: LW]};
`else
  localparam logic [1:0] BURST = AXI_BURST_INCR;
  assign start_addr = refill_addr & ~LINE_MASK;
  assign start_idx  = '0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      idx_q    <= '0;
      rcv_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      idx_q    <= idx_d;
      rcv_q    <= rcv_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    idx_d    = idx_q;
    rcv_d    = rcv_q;
    err_d    = err_q;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_req) begin
          araddr_d = start_addr;
          idx_d    = start_idx;
          rcv_d    = '0;
          err_d    = 1'b0;
          state_d  = AR;
        end
      end
      AR: begin
        if (arready) state_d = R;
      end
      R: begin
        if (rvalid) begin
          buf_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          rcv_d  = rcv_q + 1'b1;
          err_d  = err_q | (rresp != AXI_RESP_OKAY) | (rid != AXI_ID);
          if (rlast) begin
            // A short burst still completes; untouched slots keep stale data.
            if (rcv_q != LAST_RCV) err_d = 1'b1;
            state_d = DONE;
          end else if (rcv_q == LAST_RCV) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rvalid && rlast) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  refill_line_buf #(
    .LINE_BEATS (LINE_BEATS),
    .IDX_W      (LW)
  ) u_line_buf (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (buf_we),
    .idx_i   (idx_q[LW-1:0]),
    .wdata_i (rdata),
    .line_o  (refill_line)
  );

  assign refill_ready = (state_q == IDLE);
  assign refill_valid = (state_q == DONE);
  assign refill_err   = (state_q == DONE) & err_q;
  assign arvalid      = (state_q == AR);
  assign rready       = (state_q == R) || (state_q == DRAIN);
  assign araddr       = araddr_q;
  assign arid         = AXI_ID;
  assign arlen        = 8'(LINE_BEATS - 1);
  assign arsize       = AXI_SIZE_8B;
  assign arburst      = BURST;

endmodule
